// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            mem_write;
  logic                  mem_src;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;

  modport master (
    output req_valid, addr, wdata, mem_write, mem_src,
    input  req_ready, resp_valid, rdata, stall
  );

  modport slave (
    input  req_valid, addr, wdata, mem_write, mem_src,
    output req_ready, resp_valid, rdata, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one outstanding access, fixed latency, byte-lane
// stores, word / sign-extended byte loads, one-cycle response strobe.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  data_mem_responder_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  src_q, src_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [7:0]            mem_q [DEPTH];

  logic                  commit;
  logic [ADDR_WIDTH-1:0] base;
  logic [3:0]            lane_we;
  logic [1:0]            lane_sh   [4];
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [7:0]            lane_byte [4];
  logic [DATA_WIDTH-1:0] word_rd;
  logic [7:0]            byte_rd;

  assign commit         = (state_q == WAIT) && (cnt_q == 4'd0);
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.stall      = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;

  // Lane mapping: a full mask ignores the low address bits (aligned word);
  // partial masks slide toward higher lanes and drop bits shifted past lane 3.
  always_comb begin
    base    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    lane_we = (mask_q == 4'hF) ? 4'hF : (mask_q << addr_q[1:0]);
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = base + ADDR_WIDTH'(k);
      lane_sh[k]   = (mask_q == 4'hF) ? 2'(k) : 2'(k) - addr_q[1:0];
      lane_byte[k] = wdata_q[8*lane_sh[k] +: 8];
    end
    word_rd = {mem_q[lane_addr[3]], mem_q[lane_addr[2]],
               mem_q[lane_addr[1]], mem_q[lane_addr[0]]};
    byte_rd = mem_q[addr_q];
  end

  // Next-state, capture and response logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    src_d        = src_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          mask_d  = bus.mem_write;
          src_d   = bus.mem_src;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (mask_q != 4'h0) rdata_d = '0;
          else if (src_q)     rdata_d = word_rd;
          else                rdata_d = {{(DATA_WIDTH-8){byte_rd[7]}}, byte_rd};
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      src_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      src_q        <= src_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  // Byte array write on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && (mask_q != 4'h0)) begin
      for (int k = 0; k < 4; k++)
        if (lane_we[k]) mem_q[lane_addr[k]] <= lane_byte[k];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder at LATENCY=2 for the main tests, one at
// LATENCY=3 for the reset-abort case. Shared stimulus is steered by sel.
module tb_data_mem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) b2 ();
  data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) b3 ();

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2));
  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3));

  logic          sel = 1'b0;
  logic          valid_t = 1'b0;
  logic [AW-1:0] addr_t = '0;
  logic [31:0]   wdata_t = '0;
  logic [3:0]    mask_t = '0;
  logic          src_t = 1'b0;

  assign b2.req_valid = valid_t && !sel;
  assign b3.req_valid = valid_t && sel;
  assign b2.addr = addr_t;      assign b3.addr = addr_t;
  assign b2.wdata = wdata_t;    assign b3.wdata = wdata_t;
  assign b2.mem_write = mask_t; assign b3.mem_write = mask_t;
  assign b2.mem_src = src_t;    assign b3.mem_src = src_t;

  logic        rdy_o, rv_o, stall_o;
  logic [31:0] rdata_o;
  assign rdy_o   = sel ? b3.req_ready  : b2.req_ready;
  assign rv_o    = sel ? b3.resp_valid : b2.resp_valid;
  assign stall_o = sel ? b3.stall      : b2.stall;
  assign rdata_o = sel ? b3.rdata      : b2.rdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request; returns rdata, edges from acceptance to response, and
  // whether stall/ready/resp_valid followed the expected shape throughout.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic src, output logic [31:0] rd, output int lat,
                        output logic ok);
    @(negedge clk);
    addr_t = a[AW-1:0]; wdata_t = wd; mask_t = m; src_t = src; valid_t = 1'b1;
    #1;
    ok = rdy_o && stall_o;
    @(posedge clk); #1;
    valid_t = 1'b0;
    lat = 0;
    while (!rv_o && lat < 40) begin
      ok = ok && stall_o && !rdy_o;
      @(posedge clk); #1;
      lat++;
    end
    ok = ok && !stall_o && !rdy_o;
    rd = rdata_o;
    @(posedge clk); #1;
    ok = ok && !rv_o && rdy_o;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ok;
  int          n_acc, n_rv, n_low;
  int          acc_e [4];
  int          rv_e  [4];
  logic [31:0] rv_d  [4];
  logic        acc, seen;

  initial begin
    // reset state
    #12;
    chk("rst_ready", {31'b0, b2.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, b2.resp_valid}, 32'd0);
    chk("rst_rdata", b2.rdata, 32'h0);
    chk("rst_stall", {31'b0, b2.stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // word store then load
    access(32'h010, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat, ok);
    chk("st_word_rdata", rd, 32'h0);
    chk("st_word_lat", 32'(lat), 32'd2);
    chk("st_word_shape", {31'b0, ok}, 32'd1);
    access(32'h010, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("ld_word", rd, 32'hDEADBEEF);
    chk("ld_word_lat", 32'(lat), 32'd2);
    chk("ld_word_shape", {31'b0, ok}, 32'd1);

    // byte lane store and loads
    access(32'h020, 32'h0, 4'hF, 1'b0, rd, lat, ok);
    access(32'h022, 32'h00000080, 4'h1, 1'b0, rd, lat, ok);
    chk("st_byte_rdata", rd, 32'h0);
    access(32'h020, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("lane_word", rd, 32'h00800000);
    access(32'h022, 32'h0, 4'h0, 1'b0, rd, lat, ok);
    chk("lane_byte_neg", rd, 32'hFFFFFF80);
    access(32'h021, 32'h0, 4'h0, 1'b0, rd, lat, ok);
    chk("lane_byte_zero", rd, 32'h0);

    // partial mask shifted by offset, and truncated past lane 3
    access(32'h050, 32'h0, 4'hF, 1'b0, rd, lat, ok);
    access(32'h051, 32'h0000BBAA, 4'h3, 1'b0, rd, lat, ok);
    access(32'h050, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("mask_shift", rd, 32'h00BBAA00);
    access(32'h053, 32'h0000DDCC, 4'h3, 1'b0, rd, lat, ok);
    access(32'h050, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("mask_trunc", rd, 32'hCCBBAA00);

    // misaligned full-mask word aligns down
    access(32'h034, 32'hA5A5A5A5, 4'hF, 1'b0, rd, lat, ok);
    access(32'h033, 32'h11223344, 4'hF, 1'b0, rd, lat, ok);
    access(32'h030, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("misalign_word", rd, 32'h11223344);
    access(32'h034, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("misalign_next", rd, 32'hA5A5A5A5);

    // wrap-around
    access(32'h404, 32'h5A5AC3C3, 4'hF, 1'b0, rd, lat, ok);
    access(32'h004, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("wrap_word", rd, 32'h5A5AC3C3);

    // handshake hold: req_valid high across two loads
    n_acc = 0; n_rv = 0; n_low = 0;
    @(negedge clk);
    addr_t = 10'h010; mask_t = 4'h0; src_t = 1'b1; valid_t = 1'b1;
    for (int e = 0; e < 8; e++) begin
      acc = valid_t && rdy_o;
      if (!rdy_o) n_low++;
      @(posedge clk); #1;
      if (acc && n_acc < 4) begin acc_e[n_acc] = e; n_acc++; end
      if (rv_o && n_rv < 4) begin rv_e[n_rv] = e; rv_d[n_rv] = rdata_o; n_rv++; end
      @(negedge clk);
      if (n_acc == 1) addr_t = 10'h020;
      if (n_acc == 2) valid_t = 1'b0;
    end
    chk("hold_n_acc", 32'(n_acc), 32'd2);
    chk("hold_n_resp", 32'(n_rv), 32'd2);
    chk("hold_ready_low", 32'(n_low), 32'd6);
    if (n_acc == 2) begin
      chk("hold_acc0", 32'(acc_e[0]), 32'd0);
      chk("hold_acc1", 32'(acc_e[1]), 32'd4);
    end
    if (n_rv == 2) begin
      chk("hold_rv0", 32'(rv_e[0]), 32'd2);
      chk("hold_rv1", 32'(rv_e[1]), 32'd6);
      chk("hold_rd0", rv_d[0], 32'hDEADBEEF);
      chk("hold_rd1", rv_d[1], 32'h00800000);
    end

    // reset abort on the LATENCY=3 responder
    sel = 1'b1;
    access(32'h040, 32'h01020304, 4'hF, 1'b0, rd, lat, ok);
    chk("l3_lat", 32'(lat), 32'd3);
    chk("l3_shape", {31'b0, ok}, 32'd1);
    @(negedge clk);
    addr_t = 10'h040; wdata_t = 32'hCAFEF00D; mask_t = 4'hF; valid_t = 1'b1;
    @(posedge clk); #1;
    valid_t = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, rdy_o}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready_async", {31'b0, rdy_o}, 32'd1);
    chk("abort_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rv_o) seen = 1'b1;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'd0);
    access(32'h040, 32'h0, 4'h0, 1'b1, rd, lat, ok);
    chk("abort_mem_kept", rd, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It is the memory-side end of the load/store control interface driven by the decoder (MEMWrite byte mask, MEMsrc word/byte load select).
- Accepts one request at a time over a valid/ready handshake and models a fixed access latency.
- Performs byte-lane stores and word or sign-extended byte loads on an internal byte array.
- Returns a one-cycle response and drives a stall line to hold the core while the access is outstanding.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 10, byte-address width. The array holds 2**ADDR_WIDTH bytes.
- LATENCY, 2, cycles spent in WAIT per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- addr  input  ADDR_WIDTH  byte address; upper address bits are not present, so addresses wrap modulo depth.
- wdata  input  DATA_WIDTH  store data.
- mem_write  input  4  store byte mask; 0 means the request is a load.
- mem_src  input  1  load size: 1 = word, 0 = byte, sign-extended.
- resp_valid  output  1  one-cycle response strobe.
- rdata  output  DATA_WIDTH  load result.
- stall  output  1  core must hold its state this cycle.

Behaviour:
- Reset values (asynchronous, active-high):
  - state = IDLE, counter = 0, resp_valid = 0, rdata = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
  - stall = (state == IDLE && req_valid) || state == WAIT. Combinational; low in RESP so the core advances on the response cycle.
- IDLE:
  - Request accepted on the edge where req_valid && req_ready.
  - addr, wdata, mem_write and mem_src are captured into registers.
  - counter loads LATENCY-1; next state WAIT.
- WAIT:
  - counter decrements each edge.
  - On the edge where counter == 0, the memory operation commits and the state moves to RESP.
  - The input request signals are ignored during WAIT.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Next edge returns to IDLE, with resp_valid back to 0.
  - rdata holds its value until the next commit.
  - A back-to-back request can be accepted on the cycle after RESP at the earliest.
- Response timing: resp_valid is high in the cycle following the LATENCY-th edge after the accepting edge. A request accepted at edge E0 gives resp_valid during cycle E(LATENCY)..E(LATENCY+1).
- Store (mem_write != 0):
  - mem_write == 4'b1111: bytes A..A+3 are written little-endian, with A = {addr[ADDR_WIDTH-1:2], 2'b00}. addr[1:0] is ignored.
  - Any other nonzero mask: effective mask = mem_write << addr[1:0], truncated to 4 lanes. Lane k writes wdata byte (k - addr[1:0]) to address A+k.
  - Example: mask 4'b0001 at addr 0x006 writes wdata[7:0] to byte 0x006 only.
  - rdata is set to 0 at commit for stores.
- Load (mem_write == 0):
  - mem_src = 1: rdata = bytes {A+3, A+2, A+1, A}, with A the aligned address.
  - mem_src = 0: rdata = sign-extension to 32 bits of the byte at the exact addr.
- Wrap-around: the address is modulo 2**ADDR_WIDTH. A word at the top aligned address does not straddle the array end because of alignment.
- Reset mid-operation:
  - Asserting rst in WAIT before the commit edge aborts the access: no array write, no resp_valid.
  - Returns to IDLE immediately (asynchronously).
- A request held with req_valid during RESP is not accepted until IDLE.
- No overlap: at most one outstanding access.

Test Plan:
- Word store then load, LATENCY=2:
  - Store 0xDEADBEEF, mask 1111, addr 0x010, accepted at edge E0. stall is high from the request cycle to E2. resp_valid is high in cycle E2..E3 with rdata = 0.
  - Word load at 0x010 returns 0xDEADBEEF, with resp_valid exactly 2 edges after acceptance.
- Byte store lanes:
  - After a word store of 0x00000000 at 0x020, store byte 0x80 (mask 0001) at addr 0x022.
  - Word load at 0x020 returns 0x00800000.
  - Byte load at 0x022 returns 0xFFFFFF80.
  - Byte load at 0x021 returns 0x00000000.
- Misaligned word: store 0x11223344 with mask 1111 at addr 0x033. A word load at 0x030 returns 0x11223344, and bytes 0x034..0x037 are unchanged.
- Wrap-around with ADDR_WIDTH=10: store a word at addr 0x404. A word load at 0x004 returns the same data.
- Reset abort:
  - Issue word store 0xCAFEF00D at 0x040. Pulse rst during WAIT, before the commit edge, with LATENCY=3.
  - No resp_valid appears; req_ready goes high asynchronously.
  - A subsequent load at 0x040 returns the prior contents, not 0xCAFEF00D.
- Handshake hold:
  - Keep req_valid high continuously with two different loads.
  - Exactly one acceptance per IDLE visit; req_ready is low in WAIT and RESP.
  - Two resp_valid pulses, each exactly one cycle, separated by LATENCY+1 idle/accept cycles.
